// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - round-robin arbiter sharing one data-memory port between core and loader
//
// Purpose: serialises core and loader accesses onto a single combinational-read
//          data memory. One transaction at a time: IDLE -> ACCESS (WAIT_CYCLES+1) -> RESP.
// Ports:
//   clk, reset                          clock (rising edge), async active-high reset
//   c_req/c_wmask/c_addr/c_wdata        core request (wmask 0 = load)
//   c_ack/c_rdata                       core one-cycle completion pulse, load data
//   l_req/l_wmask/l_addr/l_wdata        loader request (wmask 0 = load)
//   l_ack/l_rdata                       loader one-cycle completion pulse, load data
//   m_wmask/m_addr/m_wdata/m_rdata      shared data-memory port
//   busy                                high whenever not IDLE
// Configuration macro: DMEM_ARB_LOADER_PRIO_EN - when defined, ties always go to
//          the loader and no last-owner state is kept.

module dmem_arbiter #(
    parameter int WAIT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        c_req,
    input  logic [3:0]  c_wmask,
    input  logic [31:0] c_addr,
    input  logic [31:0] c_wdata,
    output logic        c_ack,
    output logic [31:0] c_rdata,
    input  logic        l_req,
    input  logic [3:0]  l_wmask,
    input  logic [31:0] l_addr,
    input  logic [31:0] l_wdata,
    output logic        l_ack,
    output logic [31:0] l_rdata,
    output logic [3:0]  m_wmask,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic [31:0] m_rdata,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    localparam logic [2:0] WAIT_INIT = 3'(WAIT_CYCLES);

    state_t      state, state_nxt;
    logic        owner;          // 1 = loader owns the current transaction
    logic        first_q;        // first ACCESS cycle: the only cycle the write mask is driven
    logic [2:0]  wcnt;
    logic [3:0]  wmask_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        grant_any;
    logic        grant_l;
    logic        last_access;

    assign grant_any   = c_req | l_req;
    assign last_access = (wcnt == 3'd0);

`ifdef DMEM_ARB_LOADER_PRIO_EN
    assign grant_l = l_req;
`else
    logic last_owner;    // 1 = loader was served last; reset to loader so the core wins the first tie

    // Loader wins when alone, or on a tie when the core was served last.
    assign grant_l = l_req & (~c_req | ~last_owner);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_owner <= 1'b1;
        end else if (state == IDLE && grant_any) begin
            last_owner <= grant_l;
        end
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        c_ack     = 1'b0;
        l_ack     = 1'b0;
        m_wmask   = 4'd0;
        busy      = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (grant_any) begin
                    state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                if (first_q) begin
                    m_wmask = wmask_q;
                end
                if (last_access) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                c_ack     = ~owner;
                l_ack     = owner;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign m_addr  = addr_q;
    assign m_wdata = wdata_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner   <= 1'b0;
            first_q <= 1'b0;
            wcnt    <= 3'd0;
            wmask_q <= 4'd0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            c_rdata <= 32'd0;
            l_rdata <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        owner   <= grant_l;
                        first_q <= 1'b1;
                        wcnt    <= WAIT_INIT;
                        wmask_q <= grant_l ? l_wmask : c_wmask;
                        addr_q  <= grant_l ? l_addr  : c_addr;
                        wdata_q <= grant_l ? l_wdata : c_wdata;
                    end
                end
                ACCESS: begin
                    first_q <= 1'b0;
                    if (!last_access) begin
                        wcnt <= wcnt - 3'd1;
                    end else if (wmask_q == 4'd0) begin
                        // Only loads update rdata; stores leave the last load result visible.
                        if (owner) begin
                            l_rdata <= m_rdata;
                        end else begin
                            c_rdata <= m_rdata;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
